// File: rtl/joy2quad_pkg.sv
// Shared types and quadrature phase helpers for the multi-channel steering encoder.
package joy2quad_pkg;

  typedef logic [1:0] quad_phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_t;

  // Forward order {A,B}: 00 -> 01 -> 11 -> 10 -> 00
  function automatic quad_phase_t quad_next(input quad_phase_t phase);
    quad_phase_t res;
    unique case (phase)
      2'b00:   res = 2'b01;
      2'b01:   res = 2'b11;
      2'b11:   res = 2'b10;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  function automatic quad_phase_t quad_prev(input quad_phase_t phase);
    quad_phase_t res;
    unique case (phase)
      2'b00:   res = 2'b10;
      2'b10:   res = 2'b11;
      2'b11:   res = 2'b01;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/joy2quad_chan.sv
// One steering channel: hold/repeat FSM with period ramp, quadrature phase,
// last-step direction and a one-cycle step strobe.
module joy2quad_chan
  import joy2quad_pkg::*;
#(
  parameter int PERIOD_W   = 5,
  parameter int MAX_PERIOD = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       accel_en,
  input  logic       left,
  input  logic       right,
  output logic [1:0] steer,
  output logic       dir,
  output logic       step_pulse
);

  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  chan_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_acc;
  quad_phase_t         phase_q, phase_d;
  logic                dir_q, dir_d;
  logic                step;
  logic                fwd, rev, same_dir;

  assign fwd      = right & ~left;
  assign rev      = left & ~right;
  // While in HOLD, dir_q is the latched held direction.
  assign same_dir = dir_q ? fwd : rev;
  assign period_acc = (accel_en && (period_q > MIN_P)) ? (period_q - PERIOD_W'(1)) : period_q;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    step     = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (fwd || rev) begin
            step    = 1'b1;
            dir_d   = fwd;
            state_d = HOLD;
          end else begin
            period_d = MAX_P;
          end
        end
        HOLD: begin
          if (!same_dir) begin
            state_d  = IDLE;
            period_d = MAX_P;
          end else if (cnt_q == '0) begin
            step = 1'b1;
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (step) begin
      phase_d  = dir_d ? quad_next(phase_q) : quad_prev(phase_q);
      period_d = period_acc;
      cnt_d    = period_acc - PERIOD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      period_q   <= MAX_P;
      cnt_q      <= '0;
      phase_q    <= 2'b00;
      dir_q      <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      step_pulse <= step;
    end
  end

  assign steer = phase_q;
  assign dir   = dir_q;

endmodule

// File: rtl/joy2quad_multi.sv
// Multi-channel joystick-to-quadrature steering encoder: one shared runtime
// prescaler feeding NUM_CH independent channel FSMs.
module joy2quad_multi
  import joy2quad_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 16,
  parameter int PERIOD_W   = 5,
  parameter int MAX_PERIOD = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [DIV_W-1:0]    clkdiv,
  input  logic                accel_en,
  input  logic [NUM_CH-1:0]   left,
  input  logic [NUM_CH-1:0]   right,
  output logic [2*NUM_CH-1:0] steer,
  output logic [NUM_CH-1:0]   dir,
  output logic [NUM_CH-1:0]   step_pulse
);

  if (NUM_CH < 1 || NUM_CH > 8 || MIN_PERIOD < 1 || MIN_PERIOD > MAX_PERIOD ||
      MAX_PERIOD >= (1 << PERIOD_W)) begin : g_bad_params
    $error("joy2quad_multi: illegal NUM_CH/MIN_PERIOD/MAX_PERIOD/PERIOD_W combination");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // >= rather than == so lowering clkdiv below the count ticks on the next edge.
  assign tick = (div_cnt >= clkdiv);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    joy2quad_chan #(
      .PERIOD_W  (PERIOD_W),
      .MAX_PERIOD(MAX_PERIOD),
      .MIN_PERIOD(MIN_PERIOD)
    ) u_chan (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .tick      (tick),
      .accel_en  (accel_en),
      .left      (left[i]),
      .right     (right[i]),
      .steer     (steer[2*i+1:2*i]),
      .dir       (dir[i]),
      .step_pulse(step_pulse[i])
    );
  end

endmodule

// File: tb/tb_joy2quad_multi.sv
// Directed bench for joy2quad_multi: per-cycle vector table plus hand-written
// prescaler and asynchronous-reset sequences.
module tb_joy2quad_multi;

  localparam int NUM_CH     = 2;
  localparam int DIV_W      = 16;
  localparam int PERIOD_W   = 5;
  localparam int MAX_PERIOD = 4;
  localparam int MIN_PERIOD = 2;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic [DIV_W-1:0] clkdiv;
  logic             accel_en;
  logic [1:0]       left, right;
  logic [3:0]       steer;
  logic [1:0]       dir, step_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  joy2quad_multi #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .PERIOD_W  (PERIOD_W),
    .MAX_PERIOD(MAX_PERIOD),
    .MIN_PERIOD(MIN_PERIOD)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .clkdiv    (clkdiv),
    .accel_en  (accel_en),
    .left      (left),
    .right     (right),
    .steer     (steer),
    .dir       (dir),
    .step_pulse(step_pulse)
  );

  typedef struct {
    bit         do_rst;
    bit         acc;
    logic [1:0] l;
    logic [1:0] r;
    logic [3:0] st;
    logic [1:0] d;
    logic [1:0] p;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit do_rst, input bit acc, input logic [1:0] l,
                              input logic [1:0] r, input logic [3:0] st,
                              input logic [1:0] d, input logic [1:0] p);
    vec_t v;
    v.do_rst = do_rst; v.acc = acc; v.l = l; v.r = r; v.st = st; v.d = d; v.p = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    Reset_n  = 1'b0;
    clkdiv   = '0;
    accel_en = 1'b0;
    left     = '0;
    right    = '0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  // Returns the cycle number of the next step_pulse[ch], or -1 on timeout.
  task automatic wait_pulse(input int ch, input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK); #1;
      if (step_pulse[ch]) begin
        at = cyc;
        return;
      end
    end
    check("pulse_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] st_or;
    int p0, p1, p2, p3, p4, p5, t0;

    // Reset held with inputs toggling
    Reset_n = 1'b0; clkdiv = '0; accel_en = 1'b1; left = '0; right = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      left  = 2'($urandom);
      right = 2'($urandom);
      @(posedge CLK); #1;
      check($sformatf("rst_hold%0d", i), {steer, dir, step_pulse}, 32'd0);
    end
    @(negedge CLK);
    left = '0; right = '0; accel_en = 1'b0; Reset_n = 1'b1;
    st_or = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      st_or |= steer;
    end
    check("idle_100", st_or, 32'd0);

    // A: fixed-rate forward on ch0, accel off
    add(1, 0, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b00);
    add(0, 0, 2'b00, 2'b01, 4'b0011, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b00, 2'b01, 4'b0011, 2'b01, 2'b00);
    add(0, 0, 2'b00, 2'b01, 4'b0010, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b00, 2'b01, 4'b0010, 2'b01, 2'b00);
    add(0, 0, 2'b00, 2'b01, 4'b0000, 2'b01, 2'b01);
    add(0, 0, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    // B: accelerating reverse on ch1: steps at k, k+3, k+5, k+7, k+9
    add(1, 1, 2'b10, 2'b00, 4'b1000, 2'b00, 2'b10);
    add(0, 1, 2'b10, 2'b00, 4'b1000, 2'b00, 2'b00);
    add(0, 1, 2'b10, 2'b00, 4'b1000, 2'b00, 2'b00);
    add(0, 1, 2'b10, 2'b00, 4'b1100, 2'b00, 2'b10);
    add(0, 1, 2'b10, 2'b00, 4'b1100, 2'b00, 2'b00);
    add(0, 1, 2'b10, 2'b00, 4'b0100, 2'b00, 2'b10);
    add(0, 1, 2'b10, 2'b00, 4'b0100, 2'b00, 2'b00);
    add(0, 1, 2'b10, 2'b00, 4'b0000, 2'b00, 2'b10);
    add(0, 1, 2'b10, 2'b00, 4'b0000, 2'b00, 2'b00);
    add(0, 1, 2'b10, 2'b00, 4'b1000, 2'b00, 2'b10);
    // C: reversal with accel on; period must restart at MAX after the idle tick
    add(1, 1, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b01);
    add(0, 1, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b00);
    add(0, 1, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b00);
    add(0, 1, 2'b00, 2'b01, 4'b0011, 2'b01, 2'b01);
    add(0, 1, 2'b01, 2'b00, 4'b0011, 2'b01, 2'b00);
    add(0, 1, 2'b01, 2'b00, 4'b0001, 2'b00, 2'b01);
    add(0, 1, 2'b01, 2'b00, 4'b0001, 2'b00, 2'b00);
    add(0, 1, 2'b01, 2'b00, 4'b0001, 2'b00, 2'b00);
    add(0, 1, 2'b01, 2'b00, 4'b0000, 2'b00, 2'b01);
    // E: both pressed freezes a non-zero phase
    add(1, 0, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++) add(0, 0, 2'b01, 2'b01, 4'b0001, 2'b01, 2'b00);
    // D: both channels step on the same tick
    add(1, 0, 2'b00, 2'b11, 4'b0101, 2'b11, 2'b11);
    add(0, 0, 2'b00, 2'b11, 4'b0101, 2'b11, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      @(negedge CLK);
      accel_en = vecs[i].acc;
      left     = vecs[i].l;
      right    = vecs[i].r;
      @(posedge CLK); #1;
      check($sformatf("v%0d_steer", i), steer, vecs[i].st);
      check($sformatf("v%0d_dir", i), dir, vecs[i].d);
      check($sformatf("v%0d_pulse", i), step_pulse, vecs[i].p);
    end

    // Prescaler: clkdiv=3 with period 4 ticks -> 16 cycles; clkdiv=1 -> 8 cycles
    do_reset();
    @(negedge CLK);
    clkdiv = 16'd3; accel_en = 1'b0; right = 2'b01;
    wait_pulse(0, 10, p0);
    check("pre_first_phase", steer, 32'h1);
    wait_pulse(0, 40, p1);
    check("pre_gap1", p1 - p0, 32'd16);
    wait_pulse(0, 40, p2);
    check("pre_gap2", p2 - p1, 32'd16);
    @(negedge CLK);
    clkdiv = 16'd1;
    wait_pulse(0, 40, p3);
    wait_pulse(0, 40, p4);
    check("pre_fast_gap1", p4 - p3, 32'd8);
    check("pre_fast_phase", steer, 32'h1);
    wait_pulse(0, 40, p5);
    check("pre_fast_gap2", p5 - p4, 32'd8);

    // Asynchronous reset between ticks while right[0] is held
    do_reset();
    @(negedge CLK);
    clkdiv = 16'd3; right = 2'b01;
    wait_pulse(0, 10, p0);
    check("ar_pre_phase", steer, 32'h1);
    @(negedge CLK);
    #2 Reset_n = 1'b0;
    #1 check("ar_immediate", {steer, dir, step_pulse}, 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    t0 = cyc;
    wait_pulse(0, 10, p1);
    check("ar_latency", p1 - t0, 32'd4);
    check("ar_phase", steer, 32'h1);
    check("ar_dir", dir, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
